bp_be_scoreboard: RTL and testbench

BP_BE_SCOREBOARD -- requirements
Module: bp_be_scoreboard

---
 rtl/bp_be_scoreboard.sv | 98 +++++++++
 tb/tb_bp_be_scoreboard.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_be_scoreboard.sv
// Long-latency writeback scoreboard for the backend issue stage.
// Tracks integer and FP destination registers with writebacks in flight, reports
// read-after-write hazards for the instruction in issue, and counts outstanding ops.
module bp_be_scoreboard #(
    parameter int unsigned max_pending_p = 4,
    parameter int unsigned cnt_width_lp  = $clog2(max_pending_p + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_i,

    input  logic                    issue_v_i,
    input  logic                    issue_iwb_v_i,
    input  logic                    issue_fwb_v_i,
    input  logic [4:0]              issue_rd_addr_i,

    input  logic                    clear_v_i,
    input  logic                    clear_fwb_i,
    input  logic [4:0]              clear_rd_addr_i,

    input  logic [4:0]              rs1_addr_i,
    input  logic [4:0]              rs2_addr_i,
    input  logic [4:0]              rs3_addr_i,
    input  logic                    irs1_v_i,
    input  logic                    irs2_v_i,
    input  logic                    frs1_v_i,
    input  logic                    frs2_v_i,
    input  logic                    frs3_v_i,

    output logic                    haz_v_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [cnt_width_lp-1:0] pending_cnt_o
);

    logic [31:0]             int_pend_r, int_pend_n;
    logic [31:0]             fp_pend_r, fp_pend_n;
    logic [cnt_width_lp-1:0] cnt_r, cnt_n;

    logic issue_accept;
    logic clear_dec;

    assign full_o        = (cnt_r == cnt_width_lp'(max_pending_p));
    assign empty_o       = (cnt_r == '0);
    assign pending_cnt_o = cnt_r;

    // Issue is dropped when full; a clear only counts down while something is pending.
    assign issue_accept = issue_v_i & ~full_o;
    assign clear_dec    = clear_v_i & ~empty_o;

    // Next-state pending vectors: clear first, then set, so a same-register set wins.
    always_comb begin
        int_pend_n = int_pend_r;
        fp_pend_n  = fp_pend_r;
        if (clear_v_i) begin
            if (clear_fwb_i) fp_pend_n[clear_rd_addr_i]  = 1'b0;
            else             int_pend_n[clear_rd_addr_i] = 1'b0;
        end
        if (issue_accept) begin
            if (issue_iwb_v_i) int_pend_n[issue_rd_addr_i] = 1'b1;
            if (issue_fwb_v_i) fp_pend_n[issue_rd_addr_i]  = 1'b1;
        end
        // x0 is hardwired zero and can never be a hazard source.
        int_pend_n[0] = 1'b0;
    end

    // Next-state counter: issue and clear in the same cycle cancel out.
    always_comb begin
        cnt_n = cnt_r;
        if (issue_accept && !clear_dec) begin
            cnt_n = cnt_r + cnt_width_lp'(1);
        end else if (!issue_accept && clear_dec) begin
            cnt_n = cnt_r - cnt_width_lp'(1);
        end
    end

    // State registers with synchronous reset overriding any issue or clear.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            int_pend_r <= '0;
            fp_pend_r  <= '0;
            cnt_r      <= '0;
        end else begin
            int_pend_r <= int_pend_n;
            fp_pend_r  <= fp_pend_n;
            cnt_r      <= cnt_n;
        end
    end

    // Hazard looks only at registered state; no bypass of this cycle's issue or clear.
    always_comb begin
        haz_v_o = (irs1_v_i & int_pend_r[rs1_addr_i])
                | (irs2_v_i & int_pend_r[rs2_addr_i])
                | (frs1_v_i & fp_pend_r[rs1_addr_i])
                | (frs2_v_i & fp_pend_r[rs2_addr_i])
                | (frs3_v_i & fp_pend_r[rs3_addr_i]);
    end

endmodule

// File: tb/tb_bp_be_scoreboard.sv
// Bench for bp_be_scoreboard: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a set-based reference model.
module tb_bp_be_scoreboard;

    localparam int unsigned MaxPend = 4;
    localparam int unsigned CntW    = $clog2(MaxPend + 1);

    logic            clk = 1'b0;
    logic            reset_i;
    logic            issue_v_i, issue_iwb_v_i, issue_fwb_v_i;
    logic [4:0]      issue_rd_addr_i;
    logic            clear_v_i, clear_fwb_i;
    logic [4:0]      clear_rd_addr_i;
    logic [4:0]      rs1_addr_i, rs2_addr_i, rs3_addr_i;
    logic            irs1_v_i, irs2_v_i, frs1_v_i, frs2_v_i, frs3_v_i;
    logic            haz_v_o, full_o, empty_o;
    logic [CntW-1:0] pending_cnt_o;

    int n_vec  = 0;
    int n_err  = 0;
    bit chk_en = 0;

    // Reference model: sets of pending registers per RF plus an integer count.
    bit m_int[32];
    bit m_fp[32];
    int m_cnt;

    always #5 clk = ~clk;

    bp_be_scoreboard #(.max_pending_p(MaxPend)) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .issue_v_i       (issue_v_i),
        .issue_iwb_v_i   (issue_iwb_v_i),
        .issue_fwb_v_i   (issue_fwb_v_i),
        .issue_rd_addr_i (issue_rd_addr_i),
        .clear_v_i       (clear_v_i),
        .clear_fwb_i     (clear_fwb_i),
        .clear_rd_addr_i (clear_rd_addr_i),
        .rs1_addr_i      (rs1_addr_i),
        .rs2_addr_i      (rs2_addr_i),
        .rs3_addr_i      (rs3_addr_i),
        .irs1_v_i        (irs1_v_i),
        .irs2_v_i        (irs2_v_i),
        .frs1_v_i        (frs1_v_i),
        .frs2_v_i        (frs2_v_i),
        .frs3_v_i        (frs3_v_i),
        .haz_v_o         (haz_v_o),
        .full_o          (full_o),
        .empty_o         (empty_o),
        .pending_cnt_o   (pending_cnt_o)
    );

    // Model update at each clock edge from the rules for issue, clear and reset.
    always @(posedge clk) begin : model
        bit acc;
        bit dec;
        if (reset_i) begin
            for (int i = 0; i < 32; i++) begin
                m_int[i] <= 1'b0;
                m_fp[i]  <= 1'b0;
            end
            m_cnt <= 0;
        end else begin
            acc = issue_v_i && (m_cnt < MaxPend);
            dec = clear_v_i && (m_cnt > 0);
            for (int i = 0; i < 32; i++) begin
                bit ni;
                bit nf;
                ni = m_int[i];
                nf = m_fp[i];
                if (clear_v_i && clear_rd_addr_i == 5'(i)) begin
                    if (clear_fwb_i) nf = 1'b0;
                    else             ni = 1'b0;
                end
                if (acc && issue_rd_addr_i == 5'(i)) begin
                    if (issue_iwb_v_i && i != 0) ni = 1'b1;
                    if (issue_fwb_v_i)           nf = 1'b1;
                end
                m_int[i] <= ni;
                m_fp[i]  <= nf;
            end
            m_cnt <= m_cnt + (acc ? 1 : 0) - (dec ? 1 : 0);
        end
    end

    // Per-cycle comparison of all outputs against the model, mid-cycle.
    always @(negedge clk) begin : compare
        bit exp_haz;
        if (chk_en) begin
            exp_haz = (irs1_v_i && m_int[rs1_addr_i]) || (irs2_v_i && m_int[rs2_addr_i])
                   || (frs1_v_i && m_fp[rs1_addr_i]) || (frs2_v_i && m_fp[rs2_addr_i])
                   || (frs3_v_i && m_fp[rs3_addr_i]);
            n_vec++;
            if (haz_v_o !== exp_haz) begin
                n_err++;
                $display("FAIL model_haz t=%0t got=%0b exp=%0b", $time, haz_v_o, exp_haz);
            end
            if (int'(pending_cnt_o) != m_cnt || $isunknown(pending_cnt_o)) begin
                n_err++;
                $display("FAIL model_cnt t=%0t got=%0d exp=%0d", $time, pending_cnt_o, m_cnt);
            end
            if (full_o !== (m_cnt == MaxPend)) begin
                n_err++;
                $display("FAIL model_full t=%0t got=%0b exp=%0b", $time, full_o, m_cnt == MaxPend);
            end
            if (empty_o !== (m_cnt == 0)) begin
                n_err++;
                $display("FAIL model_empty t=%0t got=%0b exp=%0b", $time, empty_o, m_cnt == 0);
            end
        end
    end

    task automatic lit(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        issue_v_i = 0; issue_iwb_v_i = 0; issue_fwb_v_i = 0; issue_rd_addr_i = 0;
        clear_v_i = 0; clear_fwb_i = 0; clear_rd_addr_i = 0;
        rs1_addr_i = 0; rs2_addr_i = 0; rs3_addr_i = 0;
        irs1_v_i = 0; irs2_v_i = 0; frs1_v_i = 0; frs2_v_i = 0; frs3_v_i = 0;
    endtask

    // Advance one edge, then return all inputs to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic issue(input logic [4:0] rd, input bit iwb, input bit fwb);
        issue_v_i = 1; issue_rd_addr_i = rd; issue_iwb_v_i = iwb; issue_fwb_v_i = fwb;
    endtask

    task automatic clear(input logic [4:0] rd, input bit fwb);
        clear_v_i = 1; clear_rd_addr_i = rd; clear_fwb_i = fwb;
    endtask

    // Present a source read and sample the hazard output after it settles.
    task automatic probe(input string name, input logic [4:0] rs1, input logic [4:0] rs3,
                         input bit irs1, input bit frs1, input bit frs3, input int exp);
        rs1_addr_i = rs1; rs3_addr_i = rs3;
        irs1_v_i = irs1; frs1_v_i = frs1; frs3_v_i = frs3;
        #1;
        lit(name, int'(haz_v_o), exp);
        irs1_v_i = 0; frs1_v_i = 0; frs3_v_i = 0;
    endtask

    initial begin
        idle_inputs();
        reset_i = 1;
        tick();
        tick();
        reset_i = 0;
        chk_en = 1;
        lit("rst_cnt", int'(pending_cnt_o), 0);
        lit("rst_empty", int'(empty_o), 1);
        lit("rst_full", int'(full_o), 0);
        probe("rst_haz", 5'd5, 5'd5, 1, 1, 1, 0);

        // Basic set and release.
        issue(5'd5, 1, 0); tick();
        probe("set_haz", 5'd5, 5'd0, 1, 0, 0, 1);
        lit("set_cnt", int'(pending_cnt_o), 1);
        clear(5'd5, 0); tick();
        probe("rel_haz", 5'd5, 5'd0, 1, 0, 0, 0);
        lit("rel_empty", int'(empty_o), 1);

        // Fill to capacity, ignored fifth issue, issue+clear while full.
        for (int r = 1; r <= 4; r++) begin
            issue(5'(r), 1, 0); tick();
        end
        lit("fill_full", int'(full_o), 1);
        lit("fill_cnt", int'(pending_cnt_o), 4);
        issue(5'd9, 1, 1); tick();
        lit("drop_cnt", int'(pending_cnt_o), 4);
        probe("drop_int9", 5'd9, 5'd0, 1, 0, 0, 0);
        probe("drop_fp9", 5'd9, 5'd0, 0, 1, 0, 0);
        issue(5'd10, 1, 0); clear(5'd1, 0); tick();
        lit("full_ic_cnt", int'(pending_cnt_o), 3);
        probe("full_ic_x10", 5'd10, 5'd0, 1, 0, 0, 0);
        for (int r = 2; r <= 4; r++) begin
            clear(5'(r), 0); tick();
        end
        lit("drain_empty", int'(empty_o), 1);

        // Same-register collision: set wins.
        issue(5'd7, 1, 0); tick();
        issue(5'd7, 1, 0); clear(5'd7, 0); tick();
        probe("coll_haz", 5'd7, 5'd0, 1, 0, 0, 1);
        lit("coll_cnt", int'(pending_cnt_o), 1);
        clear(5'd7, 0); tick();

        // RF separation and x0.
        issue(5'd3, 0, 1); tick();
        probe("sep_int3", 5'd3, 5'd0, 1, 0, 0, 0);
        probe("sep_fp3", 5'd0, 5'd3, 0, 0, 1, 1);
        issue(5'd0, 1, 0); tick();
        lit("x0_cnt", int'(pending_cnt_o), 2);
        probe("x0_haz", 5'd0, 5'd0, 1, 0, 0, 0);
        clear(5'd3, 1); tick();
        clear(5'd0, 0); tick();

        // Spurious clear at zero.
        clear(5'd12, 0); tick();
        lit("spur_cnt", int'(pending_cnt_o), 0);
        lit("spur_empty", int'(empty_o), 1);

        // Reset mid-operation with a same-cycle issue.
        for (int r = 1; r <= 3; r++) begin
            issue(5'(r), 1, 1); tick();
        end
        reset_i = 1; issue(5'd4, 1, 1); tick();
        reset_i = 0;
        lit("mrst_cnt", int'(pending_cnt_o), 0);
        probe("mrst_haz1", 5'd1, 5'd2, 1, 1, 1, 0);
        irs2_v_i = 1; rs2_addr_i = 5'd2; frs2_v_i = 1; #1;
        lit("mrst_haz2", int'(haz_v_o), 0);
        idle_inputs();

        // Randomized traffic on a small register window to force collisions.
        for (int c = 0; c < 3000; c++) begin
            reset_i = ($urandom_range(0, 199) == 0);
            issue_v_i = ($urandom_range(0, 99) < 55);
            issue_iwb_v_i = $urandom_range(0, 1);
            issue_fwb_v_i = $urandom_range(0, 1);
            issue_rd_addr_i = 5'($urandom_range(0, 7));
            clear_v_i = ($urandom_range(0, 99) < 50);
            clear_fwb_i = $urandom_range(0, 1);
            clear_rd_addr_i = 5'($urandom_range(0, 7));
            // Keep away from issue+clear at an empty count.
            if (m_cnt == 0 && issue_v_i) clear_v_i = 0;
            rs1_addr_i = 5'($urandom_range(0, 7));
            rs2_addr_i = 5'($urandom_range(0, 7));
            rs3_addr_i = 5'($urandom_range(0, 7));
            irs1_v_i = $urandom_range(0, 1);
            irs2_v_i = $urandom_range(0, 1);
            frs1_v_i = $urandom_range(0, 1);
            frs2_v_i = $urandom_range(0, 1);
            frs3_v_i = $urandom_range(0, 1);
            @(posedge clk);
            #1;
        end
        reset_i = 0;
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
